// File: rtl/dmem_tag_responder_pkg.sv
// dmem_tag_responder_pkg: bus command encoding, tag width and in-flight load record
package dmem_tag_responder_pkg;
    localparam int XLEN        = 32;
    localparam int DATA_LENGTH = 64;
    localparam int MEM_TAG_W   = 4;
    localparam int CNT_W       = 8;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_LOAD  = 2'd1,
        BUS_STORE = 2'd2
    } bus_command_e;

    typedef struct packed {
        logic [MEM_TAG_W-1:0]   tag;
        logic [DATA_LENGTH-1:0] data;
        logic [CNT_W-1:0]       countdown;
    } mem_inflight_t;

    // Tags run 1..15 and skip 0, which means "no tag" on the bus.
    function automatic logic [MEM_TAG_W-1:0] tag_next(input logic [MEM_TAG_W-1:0] t);
        return (t == '1) ? MEM_TAG_W'(1) : t + 1'b1;
    endfunction
endpackage

// File: rtl/dmem_tag_responder_mem_inflight_fifo.sv
// mem_inflight_fifo: in-order queue of accepted loads, each counting down to its return cycle
module mem_inflight_fifo
    import dmem_tag_responder_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  mem_inflight_t push_entry,
    input  logic          pop,
    output logic          full,
    output logic          head_ready,
    output mem_inflight_t head
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    mem_inflight_t entries [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full       = count == (PW+1)'(DEPTH);
    assign head       = entries[rd_ptr];
    assign head_ready = (count != '0) && (head.countdown == '0);

    // Countdowns saturate at 0; a freshly pushed entry starts at its full count.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++)
            if (entries[i].countdown != '0) entries[i].countdown <= entries[i].countdown - 1'b1;
        if (push) entries[wr_ptr] <= push_entry;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= inc(wr_ptr);
            if (pop) rd_ptr <= inc(rd_ptr);
            count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
        end
    end
endmodule

// File: rtl/dmem_tag_responder.sv
// dmem_tag_responder: split-transaction data memory granting tags and returning loads after a fixed latency
module dmem_tag_responder
    import dmem_tag_responder_pkg::*;
#(
    parameter int LATENCY   = 10,
    parameter int MAX_OUTST = 8,
    parameter int MEM_WORDS = 8192
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             proc2mem_command,
    input  logic [XLEN-1:0]        proc2mem_addr,
    input  logic [DATA_LENGTH-1:0] proc2mem_data,
    output logic [MEM_TAG_W-1:0]   mem2proc_response,
    output logic [DATA_LENGTH-1:0] mem2proc_data,
    output logic [MEM_TAG_W-1:0]   mem2proc_tag
);
    localparam int IW = $clog2(MEM_WORDS);

    logic [DATA_LENGTH-1:0] mem [MEM_WORDS];
    logic [IW-1:0]          index;
    logic [MEM_TAG_W-1:0]   next_tag;
    logic                   is_load, is_store, accept_load, accept;
    logic                   full, head_ready;
    mem_inflight_t          head, push_entry;
    logic                   unused_bits;

    assign index       = proc2mem_addr[3 +: IW];
    assign is_load     = proc2mem_command == BUS_LOAD;
    assign is_store    = proc2mem_command == BUS_STORE;
    // A load may take the slot the head vacates in this same cycle.
    assign accept_load = is_load && (!full || head_ready);
    assign mem2proc_response = (!rst && (is_store || accept_load)) ? next_tag : '0;
    assign accept      = mem2proc_response != '0;
    assign push_entry  = '{tag: next_tag, data: mem[index], countdown: CNT_W'(LATENCY - 1)};
    assign unused_bits = ^{proc2mem_addr[2:0], proc2mem_addr[XLEN-1:3+IW], head.countdown};

    mem_inflight_fifo #(.DEPTH(MAX_OUTST)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (accept && is_load),
        .push_entry (push_entry),
        .pop        (head_ready),
        .full       (full),
        .head_ready (head_ready),
        .head       (head)
    );

    always_ff @(posedge clk) begin
        if (accept && is_store) mem[index] <= proc2mem_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            next_tag      <= MEM_TAG_W'(1);
            mem2proc_tag  <= '0;
            mem2proc_data <= '0;
        end else begin
            if (accept) next_tag <= tag_next(next_tag);
            mem2proc_tag <= head_ready ? head.tag : '0;
            if (head_ready) mem2proc_data <= head.data;
        end
    end
endmodule

// File: tb/tb_dmem_tag_responder.sv
// tb_dmem_tag_responder: directed scenarios plus random traffic against a queue-based reference model
module tb_dmem_tag_responder;
    import dmem_tag_responder_pkg::*;

    localparam int L  = 10;
    localparam int MO = 8;
    localparam int MW = 8192;

    logic        clk = 0;
    logic        rst = 1;
    logic [1:0]  cmd = 2'd0;
    logic [31:0] addr = '0;
    logic [63:0] wdata = '0;
    logic [3:0]  resp, tag;
    logic [63:0] data;

    dmem_tag_responder #(.LATENCY(L), .MAX_OUTST(MO), .MEM_WORDS(MW)) dut (
        .clk               (clk),
        .rst               (rst),
        .proc2mem_command  (cmd),
        .proc2mem_addr     (addr),
        .proc2mem_data     (wdata),
        .mem2proc_response (resp),
        .mem2proc_data     (data),
        .mem2proc_tag      (tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          tag;
        logic [63:0] data;
        bit          known;
        int          due;
    } pend_t;

    int          checks = 0;
    int          errors = 0;
    pend_t       pend[$];
    logic [63:0] mm[int];
    int          ntag = 1;
    int          k = 0;
    int          exp_tag = 0;
    logic [63:0] exp_data = '0;
    bit          data_known = 1;
    int          last_resp;
    int          comp_tag[$];
    int          comp_edge[$];
    logic [63:0] comp_data[$];
    logic [31:0] pool[16];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // One bus cycle: drive, check the combinational grant, advance the model one edge, check outputs.
    task automatic step(input logic [1:0] c, input logic [31:0] a, input logic [63:0] d);
        int live, idx, er;
        cmd = c; addr = a; wdata = d;
        #1;
        live = 0;
        foreach (pend[i]) if (pend[i].due > k) live++;
        er = (c == BUS_STORE || (c == BUS_LOAD && live < MO)) ? ntag : 0;
        check("response", {60'd0, resp}, 64'(er));
        last_resp = int'(resp);
        @(posedge clk);
        idx = int'((a >> 3) % MW);
        if (er != 0) begin
            if (c == BUS_STORE) mm[idx] = d;
            else pend.push_back('{tag: ntag, data: mm.exists(idx) ? mm[idx] : 64'd0,
                                  known: mm.exists(idx), due: k + L});
            ntag = ntag % 15 + 1;
        end
        exp_tag = 0;
        if (pend.size() > 0 && pend[0].due == k) begin
            exp_tag    = pend[0].tag;
            exp_data   = pend[0].data;
            data_known = pend[0].known;
            void'(pend.pop_front());
        end
        k++;
        #1;
        check("tag", {60'd0, tag}, 64'(exp_tag));
        if (data_known) check("data", data, exp_data);
        if (tag != 0) begin
            comp_tag.push_back(int'(tag));
            comp_edge.push_back(k - 1);
            comp_data.push_back(data);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(BUS_NONE, 32'd0, 64'd0);
    endtask

    task automatic clear_comps();
        comp_tag.delete();
        comp_edge.delete();
        comp_data.delete();
    endtask

    // Reset is raised wherever the caller is in the cycle; outputs must clear at once.
    task automatic do_reset();
        rst = 1; cmd = BUS_LOAD; addr = 32'h40;
        #1;
        check("reset_resp", {60'd0, resp}, 64'd0);
        check("reset_tag", {60'd0, tag}, 64'd0);
        check("reset_data", data, 64'd0);
        pend.delete();
        ntag = 1; exp_tag = 0; exp_data = '0; data_known = 1;
        repeat (2) begin @(posedge clk); k++; end
        @(negedge clk);
        rst = 0; cmd = BUS_NONE;
    endtask

    function automatic int first_or(input int q[$], input int i);
        return (q.size() > i) ? q[i] : -1;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        int r;
        repeat (2) @(posedge clk);
        k = 2;
        do_reset();

        // idle after reset
        idle(20);
        check("idle_resp", {60'd0, resp}, 64'd0);

        // store then load, fixed-latency return
        clear_comps();
        step(BUS_STORE, 32'h40, 64'hDEAD_BEEF_0000_0001);
        check("t2_store_resp", 64'(last_resp), 64'd1);
        step(BUS_LOAD, 32'h40, 64'd0);
        check("t2_load_resp", 64'(last_resp), 64'd2);
        first = k - 1;
        idle(L);
        check("t2_tag", 64'(first_or(comp_tag, 0)), 64'd2);
        check("t2_when", 64'(first_or(comp_edge, 0)), 64'(first + L));
        check("t2_data", (comp_data.size() > 0) ? comp_data[0] : 64'd0, 64'hDEAD_BEEF_0000_0001);

        // back-to-back loads fill the queue; ninth is refused
        do_reset();
        clear_comps();
        first = k;
        for (int i = 0; i < 9; i++) begin
            step(BUS_LOAD, 32'h40, 64'd0);
            check("t3_resp", 64'(last_resp), 64'((i < 8) ? i + 1 : 0));
        end
        idle(L + 4);
        check("t3_count", 64'(comp_tag.size()), 64'd8);
        for (int i = 0; i < 8; i++) begin
            check("t3_tag", 64'(first_or(comp_tag, i)), 64'(i + 1));
            check("t3_edge", 64'(first_or(comp_edge, i)), 64'(first + L + i));
        end

        // tag wrap skips 0
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(BUS_STORE, 32'h1000 + 32'(i * 8), 64'(i));
            check("t4_resp", 64'(last_resp), 64'(i % 15 + 1));
        end

        // load samples data at acceptance, not at return
        step(BUS_STORE, 32'h80, 64'h11);
        idle(2);
        clear_comps();
        step(BUS_LOAD, 32'h80, 64'd0);
        step(BUS_STORE, 32'h80, 64'h22);
        idle(L + 2);
        check("t5_old", (comp_data.size() > 0) ? comp_data[0] : 64'd0, 64'h11);
        step(BUS_LOAD, 32'h80, 64'd0);
        idle(L + 2);
        check("t5_new", (comp_data.size() > 1) ? comp_data[1] : 64'd0, 64'h22);

        // reset with loads in flight
        clear_comps();
        step(BUS_LOAD, 32'h40, 64'd0);
        step(BUS_LOAD, 32'h80, 64'd0);
        step(BUS_LOAD, 32'h40, 64'd0);
        idle(2);
        #2;
        do_reset();
        idle(L + 5);
        check("t6_no_stale", 64'(comp_tag.size()), 64'd0);
        step(BUS_LOAD, 32'h80, 64'd0);
        check("t6_resp", 64'(last_resp), 64'd1);
        idle(L);
        check("t6_tag", 64'(first_or(comp_tag, 0)), 64'd1);
        check("t6_data", (comp_data.size() > 0) ? comp_data[0] : 64'd0, 64'h22);

        // random traffic over a small pool, some addresses aliasing past the array
        for (int i = 0; i < 16; i++) begin
            pool[i] = 32'((i * 523) % MW) * 8 + ((i % 3 == 0) ? 32'(MW * 8) : 32'd0);
            step(BUS_STORE, pool[i], {$urandom, $urandom});
        end
        repeat (3000) begin
            r = $urandom_range(0, 99);
            step((r < 70) ? BUS_LOAD : (r < 88) ? BUS_STORE : BUS_NONE,
                 pool[$urandom_range(0, 15)] | 32'($urandom_range(0, 7)), {$urandom, $urandom});
        end
        idle(L + 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
